icache_line_buffer: RTL and testbench
=====================================

# icache_line_buffer

Single-line instruction fetch buffer that answers the prefetch stage's word requests and refills itself from the instruction memory bus on a miss. It sits between the prefetch FIFO (request side: address + request; response side: ack + 32-bit word) and the memory/MMU-translated fetch path. It is the responder end of the prefetch fetch protocol. It holds one aligned line of `LINE_WORDS` words with a tag and a valid bit.

## Interface
- `XLEN`, 32, address width.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush_i` input 1: invalidate the line and cancel any pending response.
- `req_i` input 1: fetch request. Each cycle it is high while the block is in IDLE counts as one new request.
- `addr_i` input XLEN: fetch physical address. `addr_i[1:0]` is ignored; word-aligned fetch only, because prefetch performs halfword realignment.
- `ack_o` output 1: response valid, one cycle per accepted request.
- `instr_o` output 32: response word; equals `32'h0000_0013` (NOP) whenever `ack_o`=0.
- `mem_req_o` output 1: memory word request; held high until `mem_ack_i`.
- `mem_addr_o` output XLEN: word address of the outstanding memory request.
- `mem_ack_i` input 1: memory word returned this cycle.
- `mem_data_i` input 32: memory data, valid with `mem_ack_i`.

## Operation
- Line fields:
  - `OFS = log2(LINE_WORDS)+2`
  - tag = `addr[XLEN-1:OFS]`
  - word index = `addr[OFS-1:2]`
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - If `req_i` is high and the access is a hit (valid and tag match), register `ack_o`=1 and `instr_o`=line[index] for the next cycle, and stay in IDLE.
  - Back-to-back hits are accepted every cycle.
  - If `req_i` is high and the access misses: latch the tag and index, clear the word counter, clear valid, and go to REFILL.
- REFILL:
  - `mem_req_o`=1 and `mem_addr_o`={latched tag, counter, 2'b00}.
  - On each `mem_ack_i`, write `mem_data_i` to line[counter] and increment the counter (mod `LINE_WORDS`).
  - After the last word is written: set valid, load the tag, and go to RESP.
  - `req_i` is ignored while in REFILL.
- RESP: `ack_o`=1 for one cycle with `instr_o`=line[latched index]; next state is IDLE. `req_i` is ignored in RESP.
- `flush_i`:
  - Valid is cleared next cycle in every state.
  - In IDLE, flush wins over a simultaneous `req_i`; the request is dropped and no ack is produced.
  - A registered hit ack in flight is still delivered, since the data predates the flush.
  - In REFILL, the outstanding word completes (wait for `mem_ack_i`), then the FSM goes to IDLE with no ack and valid=0.
  - In RESP, the ack is suppressed and the FSM goes to IDLE.
- Reset:
  - state=IDLE, valid=0, counter=0.
  - `ack_o`=0, `instr_o`=NOP, `mem_req_o`=0, `mem_addr_o`=0.
  - Line data is not reset.

## Timing
- Hit: request in cycle N gives `ack_o` in cycle N+1.
- Miss with memory latency L cycles/word, no CWF:
  - `mem_req_o` rises in N+1.
  - The last `mem_ack_i` arrives in cycle M.
  - RESP/`ack_o` is in M+1.
  - Earliest ack with zero-wait memory is N+1+LINE_WORDS.
- `mem_req_o` stays high continuously through REFILL. `mem_addr_o` advances in the cycle after each `mem_ack_i`.
- `rst` during REFILL drops `mem_req_o` the next cycle. The memory side must tolerate an abandoned request.

## Configuration
- `ICACHE_LB_CWF_EN` defined (critical word first):
  - REFILL starts the counter at the latched index and wraps.
  - The cycle after the first `mem_ack_i`, `ack_o`=1 with that word, while REFILL continues for the remaining words.
  - After the last word the FSM goes directly to IDLE; RESP is unused.
  - A flush before completion still suppresses nothing already acked.
- `ICACHE_LB_CWF_EN` undefined: sequential refill from word 0, with the ack in RESP after the full line.

## Test plan
- Reset, then `req_i`=1, `addr_i`=0x1004 (miss):
  - `mem_addr_o` sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - Memory returns 0xA0..0xA3.
  - `ack_o` fires one cycle after the fourth `mem_ack_i`, with `instr_o`=0xA1.
- Hit streaming after fill: requests 0x1000, 0x1008, 0x100E on consecutive cycles give acks on consecutive cycles with 0xA0, 0xA2, 0xA3. This also checks that `addr[1:0]` is ignored.
- Tag miss at 0x2000 after the fill of 0x1000: a new refill starts and the old line is replaced. A later request to 0x1000 misses again.
- `flush_i` asserted during the second refill word: the outstanding word completes, no `ack_o` follows, the FSM returns to IDLE, and a request to 0x1000 then misses.
- `flush_i` and `req_i` (hit address) in the same cycle: no ack, and valid is cleared.
- With `ICACHE_LB_CWF_EN`, a miss at 0x1008:
  - `mem_addr_o` sequence is 0x1008, 0x100C, 0x1000, 0x1004.
  - `ack_o` comes one cycle after the first `mem_ack_i`.
  - Requests during the rest of the refill get no ack.

Source files
------------

// File: rtl/icache_line_buffer.sv
// Single-line instruction fetch buffer: answers word fetches from one cached line, refills on miss.
// Optional critical-word-first refill when ICACHE_LB_CWF_EN is defined.
module icache_line_buffer #(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] addr_i,
    output logic            ack_o,
    output logic [31:0]     instr_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [31:0]     mem_data_i
);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFS = IW + 2;
    localparam int TW  = XLEN - OFS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]                   state;
    logic                         valid;
    logic [TW-1:0]                tag, lat_tag;
    logic [IW-1:0]                lat_idx, cnt;
    logic                         flush_pend;
    logic                         ack_q;
    logic [31:0]                  instr_q;
    logic [LINE_WORDS-1:0][31:0]  line;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic          hit, last_word, abort, resp_ack;
    logic          unused_addr_lsb;

    assign req_tag         = addr_i[XLEN-1:OFS];
    assign req_idx         = addr_i[OFS-1:2];
    assign unused_addr_lsb = ^addr_i[1:0];
    assign hit             = valid && (tag == req_tag);
    // A flush seen during refill abandons the line once the outstanding word lands.
    assign abort           = flush_i | flush_pend;

`ifdef ICACHE_LB_CWF_EN
    logic first;
    assign last_word = (cnt + IW'(1)) == lat_idx;
`else
    assign last_word = cnt == IW'(LINE_WORDS - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid      <= 1'b0;
            tag        <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            ack_q      <= 1'b0;
            instr_q    <= NOP;
`ifdef ICACHE_LB_CWF_EN
            first      <= 1'b0;
`endif
        end else begin
            ack_q   <= 1'b0;
            instr_q <= NOP;
            case (state)
                S_IDLE: begin
                    flush_pend <= 1'b0;
                    if (req_i && !flush_i) begin
                        if (hit) begin
                            ack_q   <= 1'b1;
                            instr_q <= line[req_idx];
                        end else begin
                            lat_tag <= req_tag;
                            lat_idx <= req_idx;
                            valid   <= 1'b0;
                            state   <= S_REFILL;
`ifdef ICACHE_LB_CWF_EN
                            cnt     <= req_idx;
                            first   <= 1'b1;
`else
                            cnt     <= '0;
`endif
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        cnt <= cnt + IW'(1);
`ifdef ICACHE_LB_CWF_EN
                        first <= 1'b0;
                        if (first && !abort) begin
                            ack_q   <= 1'b1;
                            instr_q <= mem_data_i;
                        end
`endif
                        if (abort) begin
                            state <= S_IDLE;
                        end else if (last_word) begin
                            valid <= 1'b1;
                            tag   <= lat_tag;
`ifdef ICACHE_LB_CWF_EN
                            state <= S_IDLE;
`else
                            state <= S_RESP;
`endif
                        end
                    end else if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (flush_i) valid <= 1'b0;
        end
    end

    // Line storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state == S_REFILL && mem_ack_i) line[cnt] <= mem_data_i;
    end

    assign resp_ack   = (state == S_RESP) && !flush_i;
    assign ack_o      = ack_q | resp_ack;
    assign instr_o    = ack_q ? instr_q : (resp_ack ? line[lat_idx] : NOP);
    assign mem_req_o  = (state == S_REFILL);
    assign mem_addr_o = (state == S_REFILL) ? {lat_tag, cnt, 2'b00} : '0;

endmodule

// File: tb/tb_icache_line_buffer.sv
// Directed bench for icache_line_buffer: refill ordering, hit streaming, tag replacement, flush, reset.
module tb_icache_line_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        ack_o;
    logic [31:0] instr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = '0;

    int n_vec = 0;
    int n_err = 0;

    icache_line_buffer #(.XLEN(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .ack_o(ack_o), .instr_o(instr_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request for one cycle.
    task automatic request(input logic [31:0] a);
        req_i  = 1'b1;
        addr_i = a;
        step();
        req_i  = 1'b0;
    endtask

    // Serve a refill already in progress; memory word w returns dbase+w, lat idle cycles per word.
    task automatic refill(input logic [31:0] line_addr, input int ridx,
                          input logic [31:0] dbase, input int lat);
        int start;
`ifdef ICACHE_LB_CWF_EN
        start = ridx;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (start + k) % 4;
            repeat (lat) begin
                chk("refill_wait_req", {31'd0, mem_req_o}, 32'd1);
                chk("refill_wait_addr", mem_addr_o, line_addr + 32'(w * 4));
                step();
            end
            chk("refill_req", {31'd0, mem_req_o}, 32'd1);
            chk("refill_addr", mem_addr_o, line_addr + 32'(w * 4));
            mem_ack_i  = 1'b1;
            mem_data_i = dbase + 32'(w);
            step();
            mem_ack_i  = 1'b0;
`ifdef ICACHE_LB_CWF_EN
            if (k == 0) begin
                chk("cwf_ack", {31'd0, ack_o}, 32'd1);
                chk("cwf_data", instr_o, dbase + 32'(ridx));
            end else begin
                chk("cwf_noack", {31'd0, ack_o}, 32'd0);
            end
`endif
        end
`ifdef ICACHE_LB_CWF_EN
        chk("cwf_done_req", {31'd0, mem_req_o}, 32'd0);
`else
        chk("resp_ack", {31'd0, ack_o}, 32'd1);
        chk("resp_data", instr_o, dbase + 32'(ridx));
        chk("resp_req", {31'd0, mem_req_o}, 32'd0);
        step();
        chk("resp_done", {31'd0, ack_o}, 32'd0);
`endif
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h13);
        chk("rst_mreq", {31'd0, mem_req_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'd0);

        // Cold miss at 0x1004, responds with word 1.
        request(32'h1004);
        chk("miss_noack", {31'd0, ack_o}, 32'd0);
        refill(32'h1000, 1, 32'hA0, 0);

        // Back-to-back hits; low address bits ignored.
        req_i = 1'b1; addr_i = 32'h1000; step();
        chk("hit0_ack", {31'd0, ack_o}, 32'd1);
        chk("hit0_data", instr_o, 32'hA0);
        addr_i = 32'h1008; step();
        chk("hit1_ack", {31'd0, ack_o}, 32'd1);
        chk("hit1_data", instr_o, 32'hA2);
        addr_i = 32'h100E; step();
        chk("hit2_ack", {31'd0, ack_o}, 32'd1);
        chk("hit2_data", instr_o, 32'hA3);
        chk("hit2_mreq", {31'd0, mem_req_o}, 32'd0);
        req_i = 1'b0; step();
        chk("idle_ack", {31'd0, ack_o}, 32'd0);
        chk("idle_nop", instr_o, 32'h13);

        // Tag miss replaces the line, slow memory.
        request(32'h2000);
        refill(32'h2000, 0, 32'hB0, 1);
        request(32'h2004);
        chk("b_hit_ack", {31'd0, ack_o}, 32'd1);
        chk("b_hit_data", instr_o, 32'hB1);
        step();

        // Old line is gone; flush during the second refill word.
        request(32'h1000);
        chk("old_miss", {31'd0, mem_req_o}, 32'd1);
        chk("old_miss_addr", mem_addr_o, 32'h1000);
        mem_ack_i = 1'b1; mem_data_i = 32'hC0; step(); mem_ack_i = 1'b0;
        chk("fl_addr1", mem_addr_o, 32'h1004);
        flush_i = 1'b1; step(); flush_i = 1'b0;
        chk("fl_hold_req", {31'd0, mem_req_o}, 32'd1);
        chk("fl_hold_addr", mem_addr_o, 32'h1004);
        mem_ack_i = 1'b1; mem_data_i = 32'hC1; step(); mem_ack_i = 1'b0;
        chk("fl_idle_req", {31'd0, mem_req_o}, 32'd0);
        chk("fl_noack", {31'd0, ack_o}, 32'd0);
        step();
        chk("fl_noack2", {31'd0, ack_o}, 32'd0);
        request(32'h1000);
        chk("fl_remiss", {31'd0, mem_req_o}, 32'd1);
        refill(32'h1000, 0, 32'hD0, 0);

        // Flush with a simultaneous hit request: dropped, line invalid.
        flush_i = 1'b1; req_i = 1'b1; addr_i = 32'h1000; step();
        flush_i = 1'b0; req_i = 1'b0;
        chk("flreq_noack", {31'd0, ack_o}, 32'd0);
        chk("flreq_mreq", {31'd0, mem_req_o}, 32'd0);
        request(32'h1000);
        chk("flreq_remiss", {31'd0, mem_req_o}, 32'd1);
        refill(32'h1000, 0, 32'hE0, 0);

        // Hit ack already registered survives a flush in its cycle.
        request(32'h1004);
        flush_i = 1'b1;
        chk("inflight_ack", {31'd0, ack_o}, 32'd1);
        chk("inflight_data", instr_o, 32'hE1);
        step();
        flush_i = 1'b0;
        chk("inflight_after", {31'd0, ack_o}, 32'd0);
        request(32'h1004);
        chk("inflight_remiss", {31'd0, mem_req_o}, 32'd1);

        // Reset during refill abandons the memory request.
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstrf_mreq", {31'd0, mem_req_o}, 32'd0);
        chk("rstrf_maddr", mem_addr_o, 32'd0);
        chk("rstrf_ack", {31'd0, ack_o}, 32'd0);
        request(32'h100C);
        chk("rstrf_miss", {31'd0, mem_req_o}, 32'd1);
        refill(32'h1000, 3, 32'hF0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
